// File: rtl/mb32_acc_pkg.sv
// Shared types and constants for consumers of the mb32_top Booth multiplier.
// Covers the group accumulator state, default latencies/widths and product sign extension.
package mb32_acc_pkg;

   localparam int MB32_WIDTH   = 32;
   localparam int MB32_MUL_LAT = 2;
   localparam int MB32_ACC_W   = 80;
   localparam int MB32_PROD_W  = 2 * MB32_WIDTH;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } acc_state_e;

   function automatic logic [MB32_ACC_W-1:0] sext_prod(input logic [MB32_PROD_W-1:0] product);
      return {{(MB32_ACC_W-MB32_PROD_W){product[MB32_PROD_W-1]}}, product};
   endfunction

endpackage

// File: rtl/mb32_vld_dly.sv
// Delay line for operand-issue {valid,last} matched to the multiplier latency.
// Lets the multiplier stay control-free while its consumers still see aligned valid/last.
module mb32_vld_dly #(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic in_last,
   output logic d_valid,
   output logic d_last,
   output logic any_valid
);

   logic [LAT-1:0] vld_r;
   logic [LAT-1:0] lst_r;

   // shift valid and qualified last through LAT stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_r <= {LAT{1'b0}};
         lst_r <= {LAT{1'b0}};
      end else begin
         vld_r[0] <= in_valid;
         lst_r[0] <= in_last & in_valid;
         for (int i = 1; i < LAT; i++) begin
            vld_r[i] <= vld_r[i-1];
            lst_r[i] <= lst_r[i-1];
         end
      end
   end

   assign d_valid   = vld_r[LAT-1];
   assign d_last    = lst_r[LAT-1];
   assign any_valid = |vld_r;

endmodule

// File: rtl/mb32_acc_stage.sv
// Group accumulator behind mb32_top: sums signed products per group and reports
// one registered result per group with a saturating term count and sticky overflow.
module mb32_acc_stage
   import mb32_acc_pkg::*;
#(
   parameter int WIDTH     = MB32_WIDTH,
   parameter int ACC_WIDTH = MB32_ACC_W,
   parameter int MUL_LAT   = MB32_MUL_LAT,
   parameter int CNT_W     = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic [2*WIDTH-1:0]   product,
   output logic                 out_valid,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0]     out_count,
   output logic                 overflow,
   output logic                 busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   acc_state_e           state_r;
   acc_state_e           state_nxt_s;
   logic [ACC_WIDTH-1:0] acc_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 ovf_r;

   logic                 d_valid_s;
   logic                 d_last_s;
   logic                 dly_busy_s;
   logic [ACC_WIDTH-1:0] term_s;
   logic [ACC_WIDTH-1:0] add_s;
   logic                 add_ovf_s;
   logic [ACC_WIDTH-1:0] acc_nxt_s;
   logic [CNT_W-1:0]     cnt_nxt_s;
   logic                 ovf_nxt_s;
   logic                 report_s;

   mb32_vld_dly #(.LAT(MUL_LAT)) u_vld_dly (
      .clk       (CLK),
      .rst_n     (RST),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .d_valid   (d_valid_s),
      .d_last    (d_last_s),
      .any_valid (dly_busy_s)
   );

   generate
      if (WIDTH == MB32_WIDTH && ACC_WIDTH == MB32_ACC_W) begin : g_pkg_sext
         assign term_s = sext_prod(product);
      end else begin : g_cast_sext
         assign term_s = ACC_WIDTH'($signed(product));
      end
   endgenerate

   // Overflow: operands agree in sign but the wrapped sum does not.
   assign add_s     = acc_r + term_s;
   assign add_ovf_s = (acc_r[ACC_WIDTH-1] == term_s[ACC_WIDTH-1]) &&
                      (add_s[ACC_WIDTH-1] != acc_r[ACC_WIDTH-1]);
   assign report_s  = d_valid_s & d_last_s;

   // state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state decode on aligned valid/last
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (d_valid_s && !d_last_s) state_nxt_s = ACC;
            else                        state_nxt_s = IDLE;
         end
         ACC: begin
            if (d_valid_s && d_last_s) state_nxt_s = IDLE;
            else                       state_nxt_s = ACC;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // datapath next values; IDLE always opens a fresh group from the incoming term
   always_comb begin
      acc_nxt_s = term_s;
      cnt_nxt_s = CNT_ONE;
      ovf_nxt_s = 1'b0;
      case (state_r)
         IDLE: begin
            acc_nxt_s = term_s;
            cnt_nxt_s = CNT_ONE;
            ovf_nxt_s = 1'b0;
         end
         ACC: begin
            acc_nxt_s = add_s;
            if (cnt_r == CNT_MAX) cnt_nxt_s = cnt_r;
            else                  cnt_nxt_s = cnt_r + CNT_ONE;
            ovf_nxt_s = ovf_r | add_ovf_s;
         end
         default: begin
            acc_nxt_s = term_s;
            cnt_nxt_s = CNT_ONE;
            ovf_nxt_s = 1'b0;
         end
      endcase
   end

   // accumulator registers advance only on an aligned valid term
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         acc_r <= {ACC_WIDTH{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
         ovf_r <= 1'b0;
      end else if (d_valid_s) begin
         acc_r <= acc_nxt_s;
         cnt_r <= cnt_nxt_s;
         ovf_r <= ovf_nxt_s;
      end else begin
         acc_r <= acc_r;
         cnt_r <= cnt_r;
         ovf_r <= ovf_r;
      end
   end

   // report registers: one-cycle pulse, result fields held until the next report
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_valid <= 1'b0;
         out_sum   <= {ACC_WIDTH{1'b0}};
         out_count <= {CNT_W{1'b0}};
         overflow  <= 1'b0;
      end else begin
         out_valid <= report_s;
         if (report_s) begin
            out_sum   <= acc_nxt_s;
            out_count <= cnt_nxt_s;
            overflow  <= ovf_nxt_s;
         end else begin
            out_sum   <= out_sum;
            out_count <= out_count;
            overflow  <= overflow;
         end
      end
   end

   assign busy = (state_r == ACC) | dly_busy_s;

endmodule

// File: tb/tb_mb32_acc_stage.sv
// Scoreboard bench for mb32_acc_stage: two instances (80-bit and 64-bit accumulator)
// share randomized and directed stimulus and are checked against an arithmetic reference model.
module tb_mb32_acc_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [63:0] product = 64'd0;

   logic        ov80, of80, busy80;
   logic [79:0] sum80;
   logic [15:0] cnt80;
   logic        ov64, of64, busy64;
   logic [63:0] sum64;
   logic [15:0] cnt64;

   mb32_acc_stage #(.WIDTH(32), .ACC_WIDTH(80), .MUL_LAT(2), .CNT_W(16)) u80 (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_last(in_last), .product(product),
      .out_valid(ov80), .out_sum(sum80), .out_count(cnt80), .overflow(of80), .busy(busy80));

   mb32_acc_stage #(.WIDTH(32), .ACC_WIDTH(64), .MUL_LAT(2), .CNT_W(16)) u64 (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_last(in_last), .product(product),
      .out_valid(ov64), .out_sum(sum64), .out_count(cnt64), .overflow(of64), .busy(busy64));

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [79:0] sum;
      int          cnt;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t q80[$];
   exp_t q64[$];
   logic [63:0] pipe[$];

   // reference model state per instance (0: 80-bit, 1: 64-bit)
   logic signed [127:0] m_sum[2];
   int                  m_cnt[2];
   logic                m_ovf[2];
   logic                m_open[2];
   logic [79:0]         h_sum[2];
   int                  h_cnt[2];
   logic                h_ovf[2];

   task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   function automatic logic signed [127:0] wrap(input logic signed [127:0] x, input int w);
      logic signed [127:0] r;
      r = x <<< (128 - w);
      r = r >>> (128 - w);
      return r;
   endfunction

   function automatic logic [79:0] to_bits(input logic signed [127:0] v, input int w);
      logic [79:0] r;
      r = v[79:0];
      if (w < 80) r = r & ((80'd1 << w) - 80'd1);
      return r;
   endfunction

   task automatic model_term(input logic signed [63:0] p, input logic l, input int c);
      logic signed [127:0] t, ex, lim;
      exp_t e;
      int w;
      t = p;
      for (int i = 0; i < 2; i++) begin
         w   = (i == 0) ? 80 : 64;
         lim = 128'sd1 <<< (w - 1);
         if (m_open[i]) begin
            ex = m_sum[i] + t;
            if (ex >= lim || ex < -lim) m_ovf[i] = 1'b1;
            m_sum[i] = wrap(ex, w);
            if (m_cnt[i] < 32'd65535) m_cnt[i]++;
         end else begin
            m_sum[i] = t;
            m_cnt[i] = 1;
            m_ovf[i] = 1'b0;
         end
         m_open[i] = !l;
         if (l) begin
            e.sum = to_bits(m_sum[i], w);
            e.cnt = m_cnt[i];
            e.ovf = m_ovf[i];
            e.cyc = c + 3;
            if (i == 0) q80.push_back(e);
            else        q64.push_back(e);
         end
      end
   endtask

   task automatic mon(input int i, input logic v, input logic [79:0] s, input logic [15:0] c,
                      input logic f);
      exp_t  e;
      string tag;
      tag = (i == 0) ? "u80" : "u64";
      if (v) begin
         if ((i == 0 && q80.size() == 0) || (i == 1 && q64.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected out_valid: got 1 expected 0 (sum %0h cycle %0d)", tag, s, cyc);
         end else begin
            if (i == 0) e = q80.pop_front();
            else        e = q64.pop_front();
            cmp({tag, " sum"},      128'(s),   128'(e.sum));
            cmp({tag, " count"},    128'(c),   128'(e.cnt));
            cmp({tag, " overflow"}, 128'(f),   128'(e.ovf));
            cmp({tag, " latency"},  128'(cyc), 128'(e.cyc));
            h_sum[i] = e.sum;
            h_cnt[i] = e.cnt;
            h_ovf[i] = e.ovf;
         end
      end else begin
         cmp({tag, " held sum"},      128'(s), 128'(h_sum[i]));
         cmp({tag, " held count"},    128'(c), 128'(h_cnt[i]));
         cmp({tag, " held overflow"}, 128'(f), 128'(h_ovf[i]));
      end
   endtask

   // monitor: compare on every falling edge while out of reset
   always @(negedge CLK) begin
      if (RST) begin
         mon(0, ov80, sum80, cnt80, of80);
         mon(1, ov64, {16'd0, sum64}, cnt64, of64);
      end
   end

   task automatic step(input logic v, input logic l, input logic signed [31:0] a,
                       input logic signed [31:0] b);
      logic signed [63:0] p;
      @(posedge CLK);
      #2;
      p        = a * b;
      in_valid = v;
      in_last  = l;
      product  = pipe.pop_front();
      pipe.push_back(v ? p : {$urandom, $urandom});
      if (v && RST) model_term(p, l, cyc);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'sd0, 32'sd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q80.size() != 0 || q64.size() != 0) && n < 40) begin
         step(1'b0, 1'b0, 32'sd0, 32'sd0);
         n++;
      end
      checks++;
      if (q80.size() != 0 || q64.size() != 0) begin
         errors++;
         $display("FAIL drain timeout: pending %0d/%0d expected 0/0", q80.size(), q64.size());
         q80.delete();
         q64.delete();
      end
      idle(2);
   endtask

   task automatic check_zero(input string nm);
      cmp({nm, " u80 out_valid"}, 128'(ov80),   128'd0);
      cmp({nm, " u80 out_sum"},   128'(sum80),  128'd0);
      cmp({nm, " u80 out_count"}, 128'(cnt80),  128'd0);
      cmp({nm, " u80 overflow"},  128'(of80),   128'd0);
      cmp({nm, " u80 busy"},      128'(busy80), 128'd0);
      cmp({nm, " u64 out_valid"}, 128'(ov64),   128'd0);
      cmp({nm, " u64 out_sum"},   128'(sum64),  128'd0);
      cmp({nm, " u64 out_count"}, 128'(cnt64),  128'd0);
      cmp({nm, " u64 overflow"},  128'(of64),   128'd0);
      cmp({nm, " u64 busy"},      128'(busy64), 128'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_open[i] = 1'b0;
         m_sum[i]  = 128'sd0;
         m_cnt[i]  = 0;
         m_ovf[i]  = 1'b0;
         h_sum[i]  = 80'd0;
         h_cnt[i]  = 0;
         h_ovf[i]  = 1'b0;
      end
      pipe.delete();
      pipe.push_back(64'd0);
      pipe.push_back(64'd0);
   endtask

   initial begin
      logic signed [31:0] mn;
      logic signed [31:0] a, b;
      logic               v, l;
      mn = 32'sh8000_0000;
      model_reset();

      // reset state
      repeat (3) @(posedge CLK);
      #3;
      check_zero("reset");
      @(posedge CLK);
      #2;
      RST = 1'b1;

      // single-term group
      step(1'b1, 1'b1, 32'sd7, 32'sd1);
      drain();

      // 4-term group with gaps
      step(1'b1, 1'b0, 32'sd5, 32'sd1);
      step(1'b0, 1'b0, 32'sd0, 32'sd0);
      cmp("busy in group u80", 128'(busy80), 128'd1);
      step(1'b1, 1'b0, -32'sd3, 32'sd1);
      idle(2);
      step(1'b1, 1'b0, 32'sd100, 32'sd1);
      idle(1);
      step(1'b1, 1'b1, -32'sd2, 32'sd1);
      drain();
      idle(3);

      // back-to-back groups
      step(1'b1, 1'b0, 32'sd2, 32'sd1);
      step(1'b1, 1'b1, 32'sd3, 32'sd1);
      step(1'b1, 1'b1, 32'sd10, 32'sd1);
      drain();

      // overflow in the 64-bit instance, then a clean group
      step(1'b1, 1'b0, mn, mn);
      step(1'b1, 1'b1, mn, mn);
      step(1'b1, 1'b1, 32'sd1, 32'sd1);
      drain();

      // in_last without in_valid is ignored
      step(1'b1, 1'b0, 32'sd3, 32'sd1);
      step(1'b0, 1'b1, 32'sd0, 32'sd0);
      step(1'b1, 1'b0, 32'sd4, 32'sd1);
      step(1'b0, 1'b1, 32'sd0, 32'sd0);
      step(1'b1, 1'b1, 32'sd5, 32'sd1);
      drain();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         v = 1'($urandom_range(0, 1));
         l = ($urandom_range(0, 3) == 0);
         a = ($urandom_range(0, 3) == 0) ? mn : $signed($urandom);
         b = ($urandom_range(0, 3) == 0) ? mn : $signed($urandom);
         step(v, l, a, b);
      end
      step(1'b1, 1'b1, 32'sd1, 32'sd1);
      drain();

      // reset mid-group with one term in flight
      step(1'b1, 1'b0, 32'sd1, 32'sd1);
      step(1'b1, 1'b0, 32'sd2, 32'sd1);
      idle(2);
      step(1'b1, 1'b0, 32'sd3, 32'sd1);
      @(posedge CLK);
      #2;
      RST      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      check_zero("mid reset");
      model_reset();
      idle(2);
      @(posedge CLK);
      #2;
      RST = 1'b1;
      step(1'b1, 1'b1, 32'sd4, 32'sd1);
      drain();
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
